// File: rtl/guardado_pkg.sv
// Shared types and constants for the keypad calculator operand path.
package guardado_pkg;

    typedef logic [3:0] digito_t;

    localparam digito_t BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        VACIO,
        PARCIAL,
        COMPLETO
    } estado_guardado_t;

endpackage

// File: rtl/validador_bcd.sv
// Combinational check that every digit of a DIGITS-wide BCD number is 0..9.
module validador_bcd
    import guardado_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic [DIGITS-1:0][3:0] numero,
    output logic                   valido
);

    always_comb begin
        // NOTE: default first so every path assigns valido and no latch is inferred.
        valido = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (digito_t'(numero[i]) > BCD_MAX) begin
                valido = 1'b0;
            end
        end
    end

endmodule

// File: rtl/guardado_operandos.sv
// Operand bank: stores up to OPERANDS BCD numbers in arrival order, flags a full bank
// for the adder, and optionally keeps a sliding window of the newest operands.
module guardado_operandos
    import guardado_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int OPERANDS     = 2,
    parameter bit SOBRESCRIBIR = 1'b0,
    localparam int CW          = $clog2(OPERANDS + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 rst_sv,
    input  logic [DIGITS-1:0][3:0]               numero,
    input  logic                                 guardar,
    output logic [OPERANDS-1:0][DIGITS-1:0][3:0] operandos,
    output logic [CW-1:0]                        cuenta,
    output logic                                 suma,
    output logic                                 nuevo,
    output logic                                 error
);

    estado_guardado_t                     r_estado;
    estado_guardado_t                     w_estado_sig;
    logic [CW-1:0]                        r_cuenta;
    logic [CW-1:0]                        w_cuenta_sig;
    logic [OPERANDS-1:0][DIGITS-1:0][3:0] r_slots;
    logic                                 r_suma;
    logic                                 r_nuevo;
    logic                                 r_error;
    logic                                 w_valido;
    logic                                 w_escribir;
    logic                                 w_desplazar;
    logic                                 w_nuevo;
    logic                                 w_error;

    validador_bcd #(.DIGITS(DIGITS)) u_validador (
        .numero (numero),
        .valido (w_valido)
    );

    always_comb begin
        w_estado_sig = r_estado;
        w_cuenta_sig = r_cuenta;
        w_escribir   = 1'b0;
        w_desplazar  = 1'b0;
        w_nuevo      = 1'b0;
        w_error      = 1'b0;
        if (guardar) begin
            if (!w_valido) begin
                w_error = 1'b1;
            end else begin
                case (r_estado)
                    VACIO, PARCIAL: begin
                        w_escribir   = 1'b1;
                        w_nuevo      = 1'b1;
                        w_cuenta_sig = r_cuenta + CW'(1);
                        w_estado_sig = (r_cuenta == CW'(OPERANDS - 1)) ? COMPLETO : PARCIAL;
                    end
                    COMPLETO: begin
                        if (SOBRESCRIBIR) begin
                            w_desplazar = 1'b1;
                            w_nuevo     = 1'b1;
                        end else begin
                            w_error = 1'b1;
                        end
                    end
                    default: w_estado_sig = VACIO;
                endcase
            end
        end
    end

    // Both resets share one path; a save in the same cycle is dropped without a pulse.
    always_ff @(posedge clk) begin
        if (rst || rst_sv) begin
            // NOTE: non-blocking everywhere in sequential logic so all registers update together.
            r_estado <= VACIO;
            r_cuenta <= '0;
            // NOTE: the slot array is reset because cleared operands are visible on the ports.
            r_slots  <= '0;
            r_suma   <= 1'b0;
            r_nuevo  <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_estado <= w_estado_sig;
            r_cuenta <= w_cuenta_sig;
            r_suma   <= (w_estado_sig == COMPLETO);
            r_nuevo  <= w_nuevo;
            r_error  <= w_error;
            for (int i = 0; i < OPERANDS; i++) begin
                if (w_escribir && (r_cuenta == CW'(i))) begin
                    r_slots[i] <= numero;
                end
            end
            if (w_desplazar) begin
                for (int i = 0; i < OPERANDS - 1; i++) begin
                    r_slots[i] <= r_slots[i+1];
                end
                r_slots[OPERANDS-1] <= numero;
            end
        end
    end

    assign operandos = r_slots;
    assign cuenta    = r_cuenta;
    assign suma      = r_suma;
    assign nuevo     = r_nuevo;
    assign error     = r_error;

endmodule

// File: doc/guardado_operandos.md
# guardado_operandos

Parametrised operand register bank for the keypad calculator path, successor to the single 4-digit BCD save register. Captures up to OPERANDS BCD numbers of DIGITS digits each, in arrival order, on a save strobe. Validates every digit and counts loaded operands. Raises `suma` once the bank is full so the downstream BCD adder can start. An optional overwrite mode keeps a sliding window of the most recent operands.

## Interface
- `DIGITS`, default 4: BCD digits per operand; must be ≥1.
- `OPERANDS`, default 2: operand slots; must be ≥2.
- `SOBRESCRIBIR`, default 0: full-bank behaviour on `guardar`. 0 rejects the save; 1 shifts the window.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high global reset.
- `rst_sv`  in  1: synchronous, active-high clear of the stored operands only.
- `numero`  in  [DIGITS-1:0][3:0]: candidate operand. Index DIGITS-1 is the most significant digit.
- `guardar`  in  1: save strobe, sampled every rising edge. Held high means one save per cycle.
- `operandos`  out  [OPERANDS-1:0][DIGITS-1:0][3:0]: stored operands. Slot 0 is the oldest.
- `cuenta`  out  $clog2(OPERANDS+1): number of valid slots, 0..OPERANDS.
- `suma`  out  1: level; high iff `cuenta == OPERANDS`.
- `nuevo`  out  1: one-cycle pulse when a save is accepted.
- `error`  out  1: one-cycle pulse when a save is rejected.

## Operation
- State machine states:
  - VACIO: `cuenta` = 0.
  - PARCIAL: `cuenta` = 1..OPERANDS-1.
  - COMPLETO: `cuenta` = OPERANDS.
- Transitions:
  - VACIO→PARCIAL on the first accepted save.
  - PARCIAL→COMPLETO when the accepted save fills the last slot.
  - Any state→VACIO on `rst` or `rst_sv`.
- Digit validity: the save is valid iff every digit of `numero` is ≤9.
- Accepted save in VACIO or PARCIAL with a valid number:
  - `operandos[cuenta]` ← `numero`.
  - `cuenta` increments.
  - `nuevo` pulses.
- Invalid digit in any state: no slot or count change; `error` pulses.
- `guardar` in COMPLETO:
  - SOBRESCRIBIR=0: rejected, `error` pulses, storage unchanged.
  - SOBRESCRIBIR=1 with a valid number: slot i ← slot i+1, last slot ← `numero`. `cuenta` stays OPERANDS, `suma` stays high, `nuevo` pulses.
- `rst_sv`:
  - All slots → 0, `cuenta` → 0, `suma` → 0.
  - Any pending `error` or `nuevo` pulse is suppressed for that cycle.
- `rst`: identical effect to `rst_sv`. It is also the power-on initialiser.
- Priority, highest first: `rst` > `rst_sv` > `guardar`. A `guardar` in the same cycle as either reset is discarded with no `error` pulse.

## Timing
- All outputs are registered. Reset values:
  - `operandos` = 0, `cuenta` = 0, `suma` = 0, `nuevo` = 0, `error` = 0.
- Latency: `guardar` sampled at edge N → `operandos`, `cuenta`, `suma`, `nuevo` and `error` all valid after edge N, in the same cycle.
- Pulses last exactly one cycle unless `guardar` stays high on the following edge.
- Back-to-back `guardar` on consecutive edges is processed one save per edge with no bubble.
- Asserting `rst_sv` in mid-sequence (PARCIAL) discards the partial operands; the next accepted save lands in slot 0.
- `suma` rises on the same edge as the save that fills the bank. It falls only on `rst` or `rst_sv`.

## Structure
- Shared package `guardado_pkg`, containing:
  - `digito_t` (logic [3:0]).
  - `BCD_MAX` = 9.
  - `estado_guardado_t` enum {VACIO, PARCIAL, COMPLETO}.
- Sub-module `validador_bcd`: combinational, parametrised by DIGITS, outputs `valido`. Reusable by the display path.
- The core is one state register, one count register, a slot array with write/shift enables, and registered pulse flags.

## Test plan
1. After `rst`, save 2165 then 9341 (DIGITS=4, OPERANDS=2), each with a one-cycle `guardar`.
   - After the first edge: slot0=2165, `cuenta`=1, `suma`=0, `nuevo`=1.
   - After the second save: slot1=9341, `cuenta`=2, `suma`=1.
2. With the bank full and SOBRESCRIBIR=0, save 0007 → `error`=1 for one cycle, slots still 2165/9341, `suma`=1.
3. With SOBRESCRIBIR=1 and slots 2165/9341, save 0007 → slots 9341/0007, `cuenta`=2, `nuevo`=1, `error`=0.
4. From VACIO, save 21A5 → `error`=1, `cuenta`=0. A following save of 2165 lands in slot 0.
5. After saving 2165 (PARCIAL), assert `rst_sv` and `guardar` with 9341 together → all slots 0, `cuenta`=0, `suma`=0, no pulse. The next save of 9341 goes to slot 0.
6. OPERANDS=3, DIGITS=6: save 123456, 000001 and 999999 with `guardar` held for 3 consecutive edges → `cuenta` 1,2,3 on successive edges, `suma` high after the third edge. A fourth edge with SOBRESCRIBIR=0 gives `error`=1.
